// File: rtl/seg_disp_arbiter_if.sv
// ----------------------------------------------------------------------------
// seg_disp_arbiter_if
//   Bundle between the message sources and the seven-segment display arbiter.
//
//   Signals
//     req       NREQ     per-source request level (source -> arbiter)
//     req_msg   16*NREQ  source i message at [16*i+15:16*i] (source -> arbiter)
//     gnt       NREQ     one-hot current owner, all-zero when idle
//     ack       1        one-cycle pulse on the first cycle of every new grant
//     owner     3        binary index of the current/last owner
//     busy      1        high whenever gnt != 0
//     disp_msg  16       message presented to the display driver
//
//   Modports
//     master  the source side: drives req/req_msg, observes the grant outputs
//     slave   the arbiter side: observes req/req_msg, drives the grant outputs
// ----------------------------------------------------------------------------
interface seg_disp_arbiter_if #(
    parameter int NREQ = 4
) ();

    logic [NREQ-1:0]    req;
    logic [16*NREQ-1:0] req_msg;
    logic [NREQ-1:0]    gnt;
    logic               ack;
    logic [2:0]         owner;
    logic               busy;
    logic [15:0]        disp_msg;

    modport master (
        output req,
        output req_msg,
        input  gnt,
        input  ack,
        input  owner,
        input  busy,
        input  disp_msg
    );

    modport slave (
        input  req,
        input  req_msg,
        output gnt,
        output ack,
        output owner,
        output busy,
        output disp_msg
    );

endinterface

// File: rtl/seg_disp_arbiter.sv
// ----------------------------------------------------------------------------
// seg_disp_arbiter
//   Shares one 4-digit seven-segment display between NREQ message sources.
//   Grants one owner at a time in round-robin order, holds each grant for at
//   least HOLD_CYCLES clocks, and drives the display driver's 16-bit message.
//   With no active grant the display shows IDLE_MSG.
//
//   Ports
//     clk   system clock
//     rst   synchronous reset, active-high
//     bus   seg_disp_arbiter_if.slave
//             in : req, req_msg
//             out: gnt, ack, owner, busy, disp_msg (all driven from registers)
//
//   Parameters
//     NREQ         number of requesters (2..8)
//     HOLD_CYCLES  minimum dwell per grant in clk cycles (>= 1)
//     CNT_W        dwell timer width, 2**CNT_W > HOLD_CYCLES-1
//     IDLE_MSG     message shown while idle
// ----------------------------------------------------------------------------
module seg_disp_arbiter #(
    parameter int          NREQ        = 4,
    parameter int          HOLD_CYCLES = 100_000_000,
    parameter int          CNT_W       = 27,
    parameter logic [15:0] IDLE_MSG    = 16'h0000
) (
    input  logic               clk,
    input  logic               rst,
    seg_disp_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHOW   = 2'd1,
        ST_EXTEND = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [NREQ-1:0]  ONE_HOT_0 = NREQ'(1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t           r_state;
    logic [CNT_W-1:0] r_timer;
    logic [2:0]       r_rr_last;
    logic [NREQ-1:0]  r_gnt;
    logic [2:0]       r_owner;
    logic             r_ack;
    logic [15:0]      r_disp_msg;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic             w_any_found;   // some source requests (rr_last included)
    logic [2:0]       w_any_idx;
    logic [15:0]      w_any_msg;
    logic             w_oth_found;   // some source other than rr_last requests
    logic [2:0]       w_oth_idx;
    logic [15:0]      w_oth_msg;
    logic             w_owner_req;
    logic [15:0]      w_owner_msg;

    state_t           w_next_state;
    logic             w_grant;
    logic [2:0]       w_win_idx;
    logic [15:0]      w_win_msg;

    logic [CNT_W-1:0] w_timer_d;
    logic [2:0]       w_rr_last_d;
    logic [NREQ-1:0]  w_gnt_d;
    logic [2:0]       w_owner_d;
    logic             w_ack_d;
    logic [15:0]      w_disp_msg_d;

    // ------------------------------------------------------------------
    // Round-robin search. Each source gets a distance from the slot just
    // after the last winner; the last winner itself is the farthest, so a
    // lone re-request by it only wins when nobody else asks. The "other"
    // search drops distance NREQ-1 (the last winner) entirely. While a grant
    // is active rr_last equals the owner, so "other" means "not the owner".
    // ------------------------------------------------------------------
    always_comb begin
        int d;
        int best_any;
        int best_oth;
        // NOTE: every signal assigned here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        d           = 0;
        best_any    = NREQ;
        best_oth    = NREQ;
        w_any_found = 1'b0;
        w_any_idx   = '0;
        w_any_msg   = '0;
        w_oth_found = 1'b0;
        w_oth_idx   = '0;
        w_oth_msg   = '0;
        w_owner_req = 1'b0;
        w_owner_msg = '0;
        for (int i = 0; i < NREQ; i++) begin
            d = (i + 2 * NREQ - 1 - int'(r_rr_last)) % NREQ;
            if (bus.req[i] && (d < best_any)) begin
                best_any    = d;
                w_any_found = 1'b1;
                w_any_idx   = 3'(i);
                w_any_msg   = bus.req_msg[16*i +: 16];
            end
            if (bus.req[i] && (d < NREQ - 1) && (d < best_oth)) begin
                best_oth    = d;
                w_oth_found = 1'b1;
                w_oth_idx   = 3'(i);
                w_oth_msg   = bus.req_msg[16*i +: 16];
            end
            if (r_owner == 3'(i)) begin
                w_owner_req = bus.req[i];
                w_owner_msg = bus.req_msg[16*i +: 16];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register (all state lives in one clocked process)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of order.
        if (rst) begin
            r_state    <= ST_IDLE;
            r_timer    <= '0;
            r_rr_last  <= 3'(NREQ - 1);
            r_gnt      <= '0;
            r_owner    <= '0;
            r_ack      <= 1'b0;
            r_disp_msg <= IDLE_MSG;
        end else begin
            r_state    <= w_next_state;
            r_timer    <= w_timer_d;
            r_rr_last  <= w_rr_last_d;
            r_gnt      <= w_gnt_d;
            r_owner    <= w_owner_d;
            r_ack      <= w_ack_d;
            r_disp_msg <= w_disp_msg_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state and grant decision
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_win_idx    = w_any_idx;
        w_win_msg    = w_any_msg;
        unique case (r_state)
            ST_IDLE: begin
                if (w_any_found) begin
                    w_next_state = ST_SHOW;
                    w_grant      = 1'b1;
                end
            end
            ST_SHOW: begin
                if (r_timer == '0) begin
                    if (w_oth_found) begin
                        // Direct hand-over, no idle bubble between owners.
                        w_next_state = ST_SHOW;
                        w_grant      = 1'b1;
                        w_win_idx    = w_oth_idx;
                        w_win_msg    = w_oth_msg;
                    end else if (w_owner_req) begin
                        w_next_state = ST_EXTEND;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            ST_EXTEND: begin
                if (w_oth_found) begin
                    w_next_state = ST_SHOW;
                    w_grant      = 1'b1;
                    w_win_idx    = w_oth_idx;
                    w_win_msg    = w_oth_msg;
                end else if (!w_owner_req) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs / datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        w_timer_d    = (r_timer != '0) ? (r_timer - 1'b1) : '0;
        w_rr_last_d  = r_rr_last;
        w_gnt_d      = r_gnt;
        w_owner_d    = r_owner;
        w_ack_d      = 1'b0;
        w_disp_msg_d = r_disp_msg;
        if (w_grant) begin
            // The message is captured on the grant edge, so a source whose
            // request drops in that same cycle still shows its message.
            w_timer_d    = HOLD_LOAD;
            w_rr_last_d  = w_win_idx;
            w_gnt_d      = ONE_HOT_0 << w_win_idx;
            w_owner_d    = w_win_idx;
            w_ack_d      = 1'b1;
            w_disp_msg_d = w_win_msg;
        end else if (w_next_state == ST_IDLE) begin
            w_timer_d    = '0;
            w_gnt_d      = '0;
            w_disp_msg_d = IDLE_MSG;
        end else if (w_owner_req) begin
            // Live tracking while the owner requests; otherwise the last
            // value is held until the dwell expires.
            w_disp_msg_d = w_owner_msg;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: every one is a register or a reduction of one
    // ------------------------------------------------------------------
    assign bus.gnt      = r_gnt;
    assign bus.ack      = r_ack;
    assign bus.owner    = r_owner;
    assign bus.busy     = |r_gnt;
    assign bus.disp_msg = r_disp_msg;

endmodule
